// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode encodings, MEM-stage FSM states and the
// EX-to-MEM payload bundle.
package pipe_pkg;

    localparam int PIPE_DATA_W    = 32;
    localparam int PIPE_REG_IDX_W = 5;
    localparam int OP_W           = 6;

    localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
    localparam logic [OP_W-1:0] OP_SUB  = 6'b000010;
    localparam logic [OP_W-1:0] OP_SUBI = 6'b000011;
    localparam logic [OP_W-1:0] OP_MUL  = 6'b000100;
    localparam logic [OP_W-1:0] OP_XOR  = 6'b001010;
    localparam logic [OP_W-1:0] OP_LDW  = 6'b001100;
    localparam logic [OP_W-1:0] OP_STW  = 6'b001101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [OP_W-1:0]           op;
        logic [PIPE_DATA_W-1:0]    rd;
        logic [PIPE_DATA_W-1:0]    addr;
        logic [PIPE_DATA_W-1:0]    wdata;
        logic [PIPE_REG_IDX_W-1:0] dst;
    } ex2mem_t;

    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return (op == OP_LDW) || (op == OP_STW);
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// Registered writeback output of the MEM stage. Merges the ALU pass-through and
// load-return paths into a one-cycle valid pulse; dst/data hold between pulses.
module mem_wb_reg #(
    parameter int DATA_W    = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_dst,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 ld_valid,
    input  logic [REG_IDX_W-1:0] ld_dst,
    input  logic [DATA_W-1:0]    ld_data,
    output logic                 wb_valid,
    output logic [REG_IDX_W-1:0] wb_dst,
    output logic [DATA_W-1:0]    wb_data
);

    logic                 valid_q, valid_d;
    logic [REG_IDX_W-1:0] dst_q,   dst_d;
    logic [DATA_W-1:0]    data_q,  data_d;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        valid_d = alu_valid || ld_valid;
        dst_d   = dst_q;
        data_d  = data_q;
        if (ld_valid) begin
            dst_d  = ld_dst;
            data_d = ld_data;
        end else if (alu_valid) begin
            dst_d  = alu_dst;
            data_d = alu_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            dst_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
        end
    end

    assign wb_valid = valid_q;
    assign wb_dst   = dst_q;
    assign wb_data  = data_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: ALU results pass to writeback, LDW/STW become handshaked
// data-memory transactions. Optional MEM_ALIGN_CHECK_EN faults misaligned accesses.
module mem_access_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W    = PIPE_DATA_W,
    parameter int ADDR_W    = 16,
    parameter int REG_IDX_W = PIPE_REG_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic [5:0]           ex_op,
    input  logic [DATA_W-1:0]    ex_rd,
    input  logic [DATA_W-1:0]    ex_addr,
    input  logic [DATA_W-1:0]    ex_wdata,
    input  logic [REG_IDX_W-1:0] ex_dst,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_W-1:0]    dmem_addr,
    output logic [DATA_W-1:0]    dmem_wdata,
    input  logic                 dmem_gnt,
    input  logic                 dmem_rvalid,
    input  logic [DATA_W-1:0]    dmem_rdata,
    output logic                 wb_valid,
    output logic [REG_IDX_W-1:0] wb_dst,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 mem_fault
);

    ex2mem_t ex_in;
    assign ex_in = '{op: ex_op, rd: ex_rd, addr: ex_addr, wdata: ex_wdata, dst: ex_dst};

    mem_state_e           state_q, state_d;
    logic [ADDR_W-1:0]    addr_q,  addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 we_q,    we_d;
    logic [REG_IDX_W-1:0] dst_q,   dst_d;

    logic accept;
    logic misaligned;
    logic alu_wb;
    logic ld_wb;
    logic fault_d;

    assign accept = ex_valid && (state_q == IDLE);

`ifdef MEM_ALIGN_CHECK_EN
    logic fault_q;
    logic unused_addr_bits;
    assign misaligned       = is_mem_op(ex_in.op) && (ex_in.addr[1:0] != 2'b00);
    assign unused_addr_bits = ^ex_in.addr[DATA_W-1:ADDR_W+2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= fault_d;
    end
    assign mem_fault = fault_q;
`else
    // Byte offset and upper address bits play no part in a word access.
    logic unused_addr_bits;
    assign misaligned       = 1'b0;
    assign unused_addr_bits = ^{ex_in.addr[DATA_W-1:ADDR_W+2], ex_in.addr[1:0], fault_d};
    assign mem_fault        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        dst_d   = dst_q;
        alu_wb  = 1'b0;
        ld_wb   = 1'b0;
        fault_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        fault_d = 1'b1;
                    end else if (is_mem_op(ex_in.op)) begin
                        addr_d  = ex_in.addr[ADDR_W+1:2];
                        wdata_d = ex_in.wdata;
                        we_d    = (ex_in.op == OP_STW);
                        dst_d   = ex_in.dst;
                        state_d = REQ;
                    end else begin
                        alu_wb = 1'b1;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) state_d = we_q ? IDLE : WAIT_RD;
            end
            WAIT_RD: begin
                // Data only counts once the request has been granted on an earlier cycle.
                if (dmem_rvalid) begin
                    ld_wb   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            dst_q   <= dst_d;
        end
    end

    assign ex_ready   = (state_q == IDLE);
    assign dmem_req   = (state_q == REQ);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

    mem_wb_reg #(
        .DATA_W    (DATA_W),
        .REG_IDX_W (REG_IDX_W)
    ) u_wb_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_wb),
        .alu_dst   (ex_in.dst),
        .alu_data  (ex_in.rd),
        .ld_valid  (ld_wb),
        .ld_dst    (dst_q),
        .ld_data   (dmem_rdata),
        .wb_valid  (wb_valid),
        .wb_dst    (wb_dst),
        .wb_data   (wb_data)
    );

endmodule
